// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: accepts parallel words on a valid/ready port, serialises
// them MSB-first and runs an overlapping pattern detector over the bit stream.
// It counts matches with saturation and raises a sticky interrupt when the
// programmed threshold is reached.
module seq_detect_ctrl #(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [PAT_W-1:0]  cfg_pattern,
   input  logic [CNT_W-1:0]  cfg_thresh,
   output logic              cfg_err,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   output logic              det_pulse,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              irq,
   input  logic              irq_clr,
   output logic              busy
);

   localparam int IDX_W = $clog2(WORD_W);
   localparam int BS_W  = $clog2(PAT_W + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state_q,     state_d;
   logic [WORD_W-1:0] shreg_q,     shreg_d;
   logic [IDX_W-1:0]  bit_idx_q,   bit_idx_d;
   logic [PAT_W-1:0]  pattern_q,   pattern_d;
   logic [CNT_W-1:0]  thresh_q,    thresh_d;
   // Only the last PAT_W-1 bits are kept; the current bit completes the window.
   logic [PAT_W-2:0]  hist_q,      hist_d;
   logic [BS_W-1:0]   bits_seen_q, bits_seen_d;
   logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
   logic              det_pulse_q, det_pulse_d;
   logic              irq_q,       irq_d;
   logic              cfg_err_q,   cfg_err_d;

   logic              cur_bit;
   logic [PAT_W-1:0]  window;
   logic              match;
   logic              cnt_full;
   logic [CNT_W-1:0]  cnt_inc;

   // Registers all state; synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bit_idx_q   <= '0;
         pattern_q   <= '0;
         thresh_q    <= '0;
         hist_q      <= '0;
         bits_seen_q <= '0;
         match_cnt_q <= '0;
         det_pulse_q <= 1'b0;
         irq_q       <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_idx_q   <= bit_idx_d;
         pattern_q   <= pattern_d;
         thresh_q    <= thresh_d;
         hist_q      <= hist_d;
         bits_seen_q <= bits_seen_d;
         match_cnt_q <= match_cnt_d;
         det_pulse_q <= det_pulse_d;
         irq_q       <= irq_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   // Next-state, datapath and decoded-output logic for the IDLE/SHIFT FSM.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_idx_d   = bit_idx_q;
      pattern_d   = pattern_q;
      thresh_d    = thresh_q;
      hist_d      = hist_q;
      bits_seen_d = bits_seen_q;
      match_cnt_d = match_cnt_q;
      det_pulse_d = 1'b0;
      irq_d       = irq_q;
      cfg_err_d   = 1'b0;
      s_ready     = 1'b0;
      busy        = 1'b0;

      cur_bit  = shreg_q[bit_idx_q];
      window   = {hist_q, cur_bit};
      match    = (state_q == SHIFT) && (window == pattern_q) &&
                 (bits_seen_q >= BS_W'(PAT_W - 1));
      cnt_full = &match_cnt_q;
      cnt_inc  = match_cnt_q + CNT_W'(1);

      if (irq_clr) begin
         irq_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            s_ready = ~cfg_we;
            if (cfg_we) begin
               // Reprogramming restarts detection and counting from scratch.
               pattern_d   = cfg_pattern;
               thresh_d    = cfg_thresh;
               hist_d      = '0;
               bits_seen_d = '0;
               match_cnt_d = '0;
               irq_d       = 1'b0;
            end else if (s_valid) begin
               shreg_d   = s_data;
               bit_idx_d = IDX_W'(WORD_W - 1);
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            busy = 1'b1;
            // Config writes mid-word are dropped and flagged.
            if (cfg_we) begin
               cfg_err_d = 1'b1;
            end
            hist_d = window[PAT_W-2:0];
            if (bits_seen_q < BS_W'(PAT_W)) begin
               bits_seen_d = bits_seen_q + BS_W'(1);
            end
            if (match) begin
               det_pulse_d = 1'b1;
               if (!cnt_full) begin
                  match_cnt_d = cnt_inc;
                  // Set has priority over a same-cycle clear.
                  if ((thresh_q != '0) && (cnt_inc == thresh_q)) begin
                     irq_d = 1'b1;
                  end
               end
            end
            if (bit_idx_q == '0) begin
               state_d = IDLE;
            end else begin
               bit_idx_d = bit_idx_q - IDX_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cfg_err   = cfg_err_q;
   assign det_pulse = det_pulse_q;
   assign match_cnt = match_cnt_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a bit-stream reference model.
module tb_seq_detect_ctrl;

   localparam int WORD_W  = 8;
   localparam int PAT_W   = 4;
   localparam int CNT_W   = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [PAT_W-1:0]  cfg_pattern;
   logic [CNT_W-1:0]  cfg_thresh;
   logic              cfg_err;
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;
   logic              det_pulse;
   logic [CNT_W-1:0]  match_cnt;
   logic              irq;
   logic              irq_clr;
   logic              busy;

   // Second instance for counter saturation (2-bit counter, 2-bit pattern).
   logic              rst_s;
   logic              cfg_we_s;
   logic [1:0]        cfg_pattern_s;
   logic [1:0]        cfg_thresh_s;
   logic              cfg_err_s;
   logic              s_valid_s;
   logic              s_ready_s;
   logic [7:0]        s_data_s;
   logic              det_pulse_s;
   logic [1:0]        match_cnt_s;
   logic              irq_s;
   logic              irq_clr_s;
   logic              busy_s;

   int tests = 0;
   int fails = 0;
   int n_pulses = 0;

   // Reference model state: pending bits of the current word, last PAT_W
   // bits seen since the last config/reset, and expected registered outputs.
   int m_pending[$];
   int m_win[$];
   int m_pat, m_thr, m_cnt;
   int m_irq, m_det, m_err;

   always #5 clk = ~clk;

   seq_detect_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_thresh(cfg_thresh), .cfg_err(cfg_err), .s_valid(s_valid),
      .s_ready(s_ready), .s_data(s_data), .det_pulse(det_pulse),
      .match_cnt(match_cnt), .irq(irq), .irq_clr(irq_clr), .busy(busy)
   );

   seq_detect_ctrl #(.WORD_W(8), .PAT_W(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst_s), .cfg_we(cfg_we_s), .cfg_pattern(cfg_pattern_s),
      .cfg_thresh(cfg_thresh_s), .cfg_err(cfg_err_s), .s_valid(s_valid_s),
      .s_ready(s_ready_s), .s_data(s_data_s), .det_pulse(det_pulse_s),
      .match_cnt(match_cnt_s), .irq(irq_s), .irq_clr(irq_clr_s), .busy(busy_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      tests++;
      assert (obs === 32'(exp)) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pending.delete();
      m_win.delete();
      m_pat = 0; m_thr = 0; m_cnt = 0;
      m_irq = 0; m_det = 0; m_err = 0;
   endtask

   // One clock cycle: drive inputs, check every output against the model,
   // then advance the model by the same clock edge.
   task automatic cycle(input logic we, input int pat, input int thr,
                        input logic vld, input int data, input logic clr,
                        input logic rs);
      int  b, v;
      bit  m_busy, set;
      logic [WORD_W-1:0] word;
      @(negedge clk);
      rst = rs; cfg_we = we; cfg_pattern = PAT_W'(pat); cfg_thresh = CNT_W'(thr);
      s_valid = vld; s_data = WORD_W'(data); irq_clr = clr;
      #1;
      m_busy = (m_pending.size() > 0);
      chk("s_ready",   32'(s_ready),   int'(!m_busy && !we));
      chk("busy",      32'(busy),      int'(m_busy));
      chk("det_pulse", 32'(det_pulse), m_det);
      chk("match_cnt", 32'(match_cnt), m_cnt);
      chk("irq",       32'(irq),       m_irq);
      chk("cfg_err",   32'(cfg_err),   m_err);
      if (det_pulse === 1'b1) n_pulses++;

      if (rs) begin
         model_reset();
      end else begin
         m_det = 0; m_err = 0; set = 0;
         if (m_busy) begin
            b = m_pending.pop_front();
            m_win.push_back(b);
            if (m_win.size() > PAT_W) void'(m_win.pop_front());
            if (we) m_err = 1;
            if (m_win.size() == PAT_W) begin
               v = 0;
               foreach (m_win[i]) v = (v << 1) | m_win[i];
               if (v == m_pat) begin
                  m_det = 1;
                  if (m_cnt < CNT_MAX) begin
                     m_cnt++;
                     if (m_thr != 0 && m_cnt == m_thr) set = 1;
                  end
               end
            end
         end else if (we) begin
            m_pat = pat; m_thr = thr;
            m_win.delete();
            m_cnt = 0; m_irq = 0;
         end else if (vld) begin
            word = WORD_W'(data);
            for (int i = WORD_W - 1; i >= 0; i--) m_pending.push_back(int'(word[i]));
         end
         if (clr) m_irq = 0;
         if (set) m_irq = 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; cfg_we = 0; cfg_pattern = '0; cfg_thresh = '0;
      s_valid = 0; s_data = '0; irq_clr = 0;
      rst_s = 1; cfg_we_s = 0; cfg_pattern_s = '0; cfg_thresh_s = '0;
      s_valid_s = 0; s_data_s = '0; irq_clr_s = 0;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset state (release happens inside the first cycle).
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("rst_s_ready", 32'(s_ready), 1);
      chk("rst_cnt",     32'(match_cnt), 0);

      // Single word 1101_1010 with pattern 1101: pulses at T5 and T8.
      cycle(1, 4'b1101, 0, 0, 0, 0, 0);
      n_pulses = 0;
      cycle(0, 0, 0, 1, 8'b1101_1010, 0, 0);
      idle(9);
      chk("t1_pulses", 32'(n_pulses), 2);
      chk("t1_cnt",    32'(match_cnt), 2);
      chk("t1_ready",  32'(s_ready), 1);

      // Cross-word match: 0000_0110 then 1000_0000 back-to-back.
      cycle(1, 4'b1101, 0, 0, 0, 0, 0);
      n_pulses = 0;
      cycle(0, 0, 0, 1, 8'b0000_0110, 0, 0);
      idle(8);
      cycle(0, 0, 0, 1, 8'b1000_0000, 0, 0);
      idle(10);
      chk("t2_pulses", 32'(n_pulses), 1);

      // Threshold 3 on pattern 1111, clear together with the 4th pulse.
      cycle(1, 4'b1111, 3, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 8'hFF, 0, 0);
      idle(7);
      chk("t3_irq_set", 32'(irq), 1);
      chk("t3_cnt3",    32'(match_cnt), 3);
      cycle(0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("t3_irq_clr", 32'(irq), 0);
      chk("t3_cnt5",    32'(match_cnt), 5);
      idle(2);

      // Config write during SHIFT is ignored and flagged.
      cycle(1, 4'b1101, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 8'b1101_1010, 0, 0);
      idle(2);
      cycle(1, 4'b0000, 5, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("t4_err",   32'(cfg_err), 1);
      idle(1);
      chk("t4_err_0", 32'(cfg_err), 0);
      idle(4);
      chk("t4_cnt",   32'(match_cnt), 2);
      // Config plus valid in IDLE: config wins, word not taken.
      cycle(1, 4'b1111, 0, 1, 8'hFF, 0, 0);
      chk("t4_ready_lo", 32'(s_ready), 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("t4_cnt_clr", 32'(match_cnt), 0);
      chk("t4_not_busy", 32'(busy), 0);

      // Reset mid-word, then a fresh word 0D with pattern 1101.
      cycle(1, 4'b1101, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 8'hFF, 0, 0);
      idle(3);
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("t5_ready", 32'(s_ready), 1);
      chk("t5_cnt",   32'(match_cnt), 0);
      chk("t5_det",   32'(det_pulse), 0);
      cycle(1, 4'b1101, 0, 0, 0, 0, 0);
      n_pulses = 0;
      cycle(0, 0, 0, 1, 8'h0D, 0, 0);
      idle(9);
      chk("t5_pulses", 32'(n_pulses), 1);

      // Random traffic against the model.
      for (int i = 0; i < 500; i++) begin
         cycle(($urandom_range(0, 15) == 0), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 6)), $urandom_range(0, 1) == 1,
               int'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 99) == 0));
      end

      // Saturation: 2-bit counter, pattern 11, word FF -> 7 pulses, count 3.
      @(negedge clk);
      rst_s = 0; cfg_we_s = 1; cfg_pattern_s = 2'b11; cfg_thresh_s = 2'd0;
      @(negedge clk);
      cfg_we_s = 0; s_valid_s = 1; s_data_s = 8'hFF;
      @(negedge clk);
      s_valid_s = 0;
      n_pulses = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (det_pulse_s === 1'b1) n_pulses++;
         @(negedge clk);
      end
      chk("sat_pulses", 32'(n_pulses), 7);
      chk("sat_cnt",    32'(match_cnt_s), 3);
      chk("sat_irq",    32'(irq_s), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
